alu_exec_unit: RTL

Multi-cycle execute sequencer that sits on the operand/result side of the existing 2-bit-op ALU.
- Accepts one RV32 instruction per valid/ready handshake (R-type ADD/SUB/AND/OR and I-type ADDI).
- Reads rs1/rs2 (or the immediate) from an internal register file and drives the ALU's A, B and op.
- Captures the ALU result and writes it back to rd.
- The ALU itself is instantiated beside this block at the top level; this block is its driver and its result consumer.

---
 rtl/rv_pkg.sv | 65 ++++++
 rtl/alu_exec_unit_if.sv | 31 +++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_exec_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 execute sequencer: ALU op codes, opcodes,
// FSM states and the instruction decoder used in IDLE.
package rv_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        use_imm;
        logic        err;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        opc       = instr[6:0];
        f3        = instr[14:12];
        f7        = instr[31:25];
        d.op      = ALU_ADD;
        d.rd      = instr[11:7];
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.imm     = instr[31:20];
        d.use_imm = 1'b0;
        d.err     = 1'b0;
        if (opc == OPC_OP && f7 == F7_BASE) begin
            case (f3)
                3'b000:  d.op = ALU_ADD;
                3'b111:  d.op = ALU_AND;
                3'b110:  d.op = ALU_OR;
                default: d.err = 1'b1;
            endcase
        end else if (opc == OPC_OP && f7 == F7_ALT && f3 == 3'b000) begin
            d.op = ALU_SUB;
        end else if (opc == OPC_OPIMM && f3 == 3'b000) begin
            d.use_imm = 1'b1;
        end else begin
            d.err = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Bundle of the execute unit's instruction, ALU, retirement and debug signals.
// slave is the execute unit; master is its environment (source, ALU, debug).
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] alu_out;
    logic            done_valid;
    logic            done_err;
    logic [4:0]      done_rd;
    logic [XLEN-1:0] done_data;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport slave (
        input  in_valid, in_instr, alu_out, dbg_addr,
        output in_ready, alu_a, alu_b, alu_op,
        output done_valid, done_err, done_rd, done_data, dbg_data
    );

    modport master (
        output in_valid, in_instr, alu_out, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_op,
        input  done_valid, done_err, done_rd, done_data, dbg_data
    );
endinterface

// File: rtl/alu_regfile.sv
// Architectural register file: three combinational read ports, one write port,
// x0 hardwired to zero.
module alu_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    input  logic [4:0]      i_dbg_addr,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_dbg_data
);
    logic [XLEN-1:0] r_regs [NREGS];

    // NOTE: this is a flop array, not a RAM macro, so it can take the async reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && i_waddr != 5'd0) begin
            // NOTE: non-blocking so every reader in this edge sees the pre-edge value.
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_exec_unit.sv
// Four-state execute sequencer (IDLE/OPER/EXEC/WB) that feeds an external
// 2-bit-op ALU from the register file and writes its result back.
module alu_exec_unit
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);
    state_e          r_state;
    state_e          w_next;
    dec_t            w_dec;

    logic [1:0]      r_op;
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [11:0]     r_imm;
    logic            r_use_imm;
    logic            r_err;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_res;

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_imm_ext;
    logic            w_we;
    logic            w_wb;

    assign w_dec     = decode(bus.in_instr);
    assign w_imm_ext = {{(XLEN-12){r_imm[11]}}, r_imm};
    assign w_wb      = (r_state == ST_WB);
    assign w_we      = w_wb && !r_err;

    alu_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (r_rs1),
        .i_rs2_addr (r_rs2),
        .i_dbg_addr (bus.dbg_addr),
        .i_we       (w_we),
        .i_waddr    (r_rd),
        .i_wdata    (r_res),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .o_dbg_data (bus.dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: default first so every path assigns w_next and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_next = ST_OPER;
            ST_OPER: w_next = r_err ? ST_WB : ST_EXEC;
            ST_EXEC: w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= ALU_ADD;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
            r_err     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op      <= w_dec.op;
                        r_rd      <= w_dec.rd;
                        r_rs1     <= w_dec.rs1;
                        r_rs2     <= w_dec.rs2;
                        r_imm     <= w_dec.imm;
                        r_use_imm <= w_dec.use_imm;
                        r_err     <= w_dec.err;
                    end
                end
                ST_OPER: begin
                    r_a <= w_rs1_data;
                    r_b <= r_use_imm ? w_imm_ext : w_rs2_data;
                end
                ST_EXEC: r_res <= bus.alu_out;
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_op     = r_op;
    assign bus.done_valid = w_wb;
    assign bus.done_err   = w_wb && r_err;
    assign bus.done_rd    = w_wb ? r_rd : 5'd0;
    // r_res is stale on an illegal instruction, so the result is forced to zero.
    assign bus.done_data  = w_we ? r_res : '0;

endmodule
